// File: rtl/serial_code_lock_pkg.sv
// Shared definitions for the serial code lock: FSM state encoding,
// default parameter values and the failure counter width.
package serial_code_lock_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        CHECK   = 3'd2,
        OPEN    = 3'd3,
        LOCKOUT = 3'd4
    } state_t;

    localparam int DEF_WIDTH          = 8;
    localparam int DEF_MAX_FAIL       = 3;
    localparam int DEF_OPEN_CYCLES    = 16;
    localparam int DEF_LOCKOUT_CYCLES = 64;
    localparam int DEF_TIMEOUT_CYCLES = 32;

    localparam int FAIL_W = 3;

endpackage

// File: rtl/eq_compare_n.sv
// WIDTH-bit equality compare: per-bit XNOR, AND-reduced; eq=1 when a==b.
module eq_compare_n #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             eq
);

    // Every bit position must agree for the words to be equal.
    assign eq = &(a ~^ b);

endmodule

// File: rtl/serial_code_lock.sv
// Serial code lock: shifts a code word in MSB first, compares it with a
// stored key, opens a timed unlock window on a match and enters a timed
// lockout after MAX_FAIL consecutive mismatches.
// Optional feature macro: SERIAL_CODE_LOCK_TIMEOUT_EN enables an inter-bit
// idle timeout that abandons a partial entry.
//
// Input handshake: bit_valid is a one-cycle strobe with no back-pressure.
// A bit is taken on any cycle bit_valid is high while the FSM is in IDLE
// (and key_load is low) or SHIFT; strobes in CHECK, OPEN or LOCKOUT are
// dropped. key_load is likewise only honoured in IDLE.
module serial_code_lock
    import serial_code_lock_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int MAX_FAIL       = DEF_MAX_FAIL,
    parameter int OPEN_CYCLES    = DEF_OPEN_CYCLES,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
`ifdef SERIAL_CODE_LOCK_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_load,
    input  logic [WIDTH-1:0]  key_in,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic              unlocked,
    output logic              alarm,
    output logic              busy,
    output logic [FAIL_W-1:0] fail_count
);

    localparam int CW   = $clog2(WIDTH + 1);
    localparam int TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0]     LAST_BIT   = CW'(WIDTH - 1);
    localparam logic [FAIL_W-1:0] FAIL_LIMIT = FAIL_W'(MAX_FAIL);
    localparam logic [TW-1:0]     OPEN_LOAD  = TW'(OPEN_CYCLES);
    localparam logic [TW-1:0]     LOCK_LOAD  = TW'(LOCKOUT_CYCLES);

`ifdef SERIAL_CODE_LOCK_TIMEOUT_EN
    localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYCLES - 1);
    logic [GW-1:0] gap;
`endif

    // FSM state is kept as a named signal so checkers can bind to it.
    state_t           state;
    logic [WIDTH-1:0] key;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bitcnt;
    logic [TW-1:0]    timer;
    logic             code_match;

    eq_compare_n #(.WIDTH(WIDTH)) u_eq (
        .a  (shreg),
        .b  (key),
        .eq (code_match)
    );

    // Lock FSM with all datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            key        <= '0;
            shreg      <= '0;
            bitcnt     <= '0;
            timer      <= '0;
            fail_count <= '0;
            unlocked   <= 1'b0;
            alarm      <= 1'b0;
            busy       <= 1'b0;
`ifdef SERIAL_CODE_LOCK_TIMEOUT_EN
            gap        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // key_load wins; a simultaneous bit is dropped.
                    if (key_load) begin
                        key <= key_in;
                    end else if (bit_valid) begin
                        shreg  <= {shreg[WIDTH-2:0], bit_in};
                        bitcnt <= CW'(1);
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (bit_valid) begin
                        shreg  <= {shreg[WIDTH-2:0], bit_in};
                        bitcnt <= bitcnt + CW'(1);
`ifdef SERIAL_CODE_LOCK_TIMEOUT_EN
                        gap    <= '0;
`endif
                        if (bitcnt == LAST_BIT) begin
                            state <= CHECK;
                        end
                    end
`ifdef SERIAL_CODE_LOCK_TIMEOUT_EN
                    else if (gap == GAP_LAST) begin
                        // Entry abandoned: discard it without counting a failure.
                        gap    <= '0;
                        bitcnt <= '0;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        gap <= gap + GW'(1);
                    end
`else
                    // Without the timeout, SHIFT waits for the next strobe indefinitely.
`endif
                end

                CHECK: begin
                    bitcnt <= '0;
                    busy   <= 1'b0;
                    if (code_match) begin
                        fail_count <= '0;
                        timer      <= OPEN_LOAD;
                        unlocked   <= 1'b1;
                        state      <= OPEN;
                    end else if (fail_count + FAIL_W'(1) == FAIL_LIMIT) begin
                        fail_count <= FAIL_LIMIT;
                        timer      <= LOCK_LOAD;
                        alarm      <= 1'b1;
                        state      <= LOCKOUT;
                    end else begin
                        fail_count <= fail_count + FAIL_W'(1);
                        state      <= IDLE;
                    end
                end

                OPEN: begin
                    if (timer == TW'(1)) begin
                        unlocked <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end

                LOCKOUT: begin
                    if (timer == TW'(1)) begin
                        alarm      <= 1'b0;
                        fail_count <= '0;
                        state      <= IDLE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end

                default: begin
                    bitcnt   <= '0;
                    busy     <= 1'b0;
                    unlocked <= 1'b0;
                    alarm    <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_code_lock.sv
// Testbench for serial_code_lock: directed scenarios plus randomized
// entries scored against a transaction-level model of the lock.
module tb_serial_code_lock;

    localparam int W        = 8;
    localparam int MAXF     = 3;
    localparam int OPEN_LEN = 16;
    localparam int LOCK_LEN = 64;
    localparam int TMO      = 32;

    localparam logic [1:0] OC_IDLE = 2'd0;
    localparam logic [1:0] OC_OPEN = 2'd1;
    localparam logic [1:0] OC_LOCK = 2'd2;

    logic         clk = 1'b0;
    logic         reset;
    logic         key_load;
    logic [W-1:0] key_in;
    logic         bit_valid;
    logic         bit_in;
    logic         unlocked;
    logic         alarm;
    logic         busy;
    logic [2:0]   fail_count;

    // model state and scoreboard
    logic [W-1:0] m_key;
    int           m_fail;
    logic [1:0]   exp_q[$];
    int           n_cmp;
    int           n_err;

    serial_code_lock dut (
        .clk        (clk),
        .reset      (reset),
        .key_load   (key_load),
        .key_in     (key_in),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .unlocked   (unlocked),
        .alarm      (alarm),
        .busy       (busy),
        .fail_count (fail_count)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load_key(input logic [W-1:0] k);
        key_load = 1'b1;
        key_in   = k;
        tick();
        key_load = 1'b0;
        m_key    = k;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        tick();
        bit_valid = 1'b0;
    endtask

    task automatic drive_noise();
        bit_valid = 1'($urandom_range(0, 1));
        bit_in    = 1'($urandom_range(0, 1));
        key_load  = 1'($urandom_range(0, 1));
        key_in    = W'($urandom);
    endtask

    task automatic quiet();
        bit_valid = 1'b0;
        key_load  = 1'b0;
    endtask

    // Called right after the last bit has been accepted: predicts the
    // outcome from the key/failure rules and checks the DUT's response.
    task automatic finish_entry(input logic [W-1:0] code);
        int         n;
        logic [1:0] obs;
        logic [1:0] exp;
        check("busy_last_bit", busy, 1);
        check("unlocked_early", unlocked, 0);
        if (code == m_key) exp_q.push_back(OC_OPEN);
        else if (m_fail + 1 == MAXF) exp_q.push_back(OC_LOCK);
        else exp_q.push_back(OC_IDLE);
        tick();
        obs = unlocked ? OC_OPEN : (alarm ? OC_LOCK : OC_IDLE);
        exp = exp_q.pop_front();
        check("outcome", obs, exp);
        check("busy_after_check", busy, 0);
        n = 0;
        if (exp == OC_OPEN) begin
            m_fail = 0;
            check("fail_on_open", fail_count, 0);
            while (unlocked && n < 100) begin
                n++;
                drive_noise();
                tick();
            end
            quiet();
            check("open_len", n, OPEN_LEN);
        end else if (exp == OC_LOCK) begin
            check("fail_on_lock", fail_count, MAXF);
            while (alarm && n < 200) begin
                n++;
                drive_noise();
                tick();
            end
            quiet();
            m_fail = 0;
            check("lock_len", n, LOCK_LEN);
            check("fail_after_lock", fail_count, 0);
        end else begin
            m_fail++;
            check("fail_count", fail_count, m_fail);
        end
    endtask

    task automatic run_entry(input logic [W-1:0] code, input int max_gap, input bit mid_load);
        for (int i = W - 1; i >= 0; i--) begin
            repeat ($urandom_range(0, max_gap)) tick();
            if (mid_load && i == 3) begin
                key_load = 1'b1;
                key_in   = ~code;
                tick();
                key_load = 1'b0;
            end
            send_bit(code[i]);
        end
        finish_entry(code);
    endtask

    initial begin
        logic [W-1:0] code;
        n_cmp = 0;
        n_err = 0;
        m_key = '0;
        m_fail = 0;
        reset = 1'b1;
        key_load = 1'b0;
        key_in = '0;
        bit_valid = 1'b0;
        bit_in = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // reset state
        check("rst_unlocked", unlocked, 0);
        check("rst_alarm", alarm, 0);
        check("rst_busy", busy, 0);
        check("rst_fail", fail_count, 0);

        // match
        load_key(8'hA5);
        send_bit(1'b1);
        check("busy_first_bit", busy, 1);
        for (int i = W - 2; i >= 0; i--) send_bit(code_bit(8'hA5, i));
        finish_entry(8'hA5);

        // mismatch then match
        load_key(8'h3C);
        run_entry(8'h3D, 0, 0);
        run_entry(8'h3C, 1, 0);

        // lockout, then the correct key still works
        load_key(8'hFF);
        run_entry(8'h00, 0, 0);
        run_entry(8'h00, 2, 0);
        run_entry(8'h00, 0, 0);
        run_entry(8'hFF, 1, 0);

        // key_load beats bit_valid in IDLE; key_load ignored mid-SHIFT
        key_load  = 1'b1;
        key_in    = 8'h5A;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        tick();
        quiet();
        m_key = 8'h5A;
        check("prio_bit_dropped", busy, 0);
        run_entry(8'h5A, 1, 1);

        // reset mid-entry clears everything including the key
        load_key(8'h77);
        run_entry(8'h78, 0, 0);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_key = '0;
        m_fail = 0;
        check("midrst_busy", busy, 0);
        check("midrst_fail", fail_count, 0);
        check("midrst_unlocked", unlocked, 0);
        check("midrst_alarm", alarm, 0);
        run_entry(8'h00, 0, 0);

        // long gap inside an entry
        load_key(8'hC3);
        run_entry(8'h13, 0, 0);
        code = 8'hC3;
        for (int i = W - 1; i >= W - 3; i--) send_bit(code[i]);
`ifdef SERIAL_CODE_LOCK_TIMEOUT_EN
        repeat (TMO - 1) tick();
        check("tmo_busy_before", busy, 1);
        tick();
        check("tmo_busy_after", busy, 0);
        check("tmo_fail_kept", fail_count, m_fail);
        run_entry(code, 0, 0);
`else
        repeat (TMO + 8) tick();
        check("wait_busy", busy, 1);
        for (int i = W - 4; i >= 0; i--) send_bit(code[i]);
        finish_entry(code);
`endif

        // randomized entries
        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 3) == 0) load_key(W'($urandom));
            if ($urandom_range(0, 1) == 0) code = m_key;
            else code = W'($urandom);
            run_entry(code, 2, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    function automatic logic code_bit(input logic [W-1:0] v, input int i);
        return v[i];
    endfunction

endmodule

// File: doc/serial_code_lock.md
Name: serial_code_lock

Overview:
- Sequential consumer of the 8-bit equality compare.
- Shifts a serially entered code word in MSB first and compares it against a stored key.
- Drives an unlock pulse window on a match. Counts consecutive failures and enters a timed lockout after too many.
- Sits between the debounced switch/button input stage and the board LEDs.

Parameters:
- WIDTH, 8: code word width in bits.
- MAX_FAIL, 3: consecutive mismatches that trigger lockout (1..7).
- OPEN_CYCLES, 16: cycles that unlocked stays high after a match.
- LOCKOUT_CYCLES, 64: cycles spent in lockout.
- TIMEOUT_CYCLES, 32: max idle gap between entry bits (optional feature only).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- key_load  in  1  store key_in as new key; honoured only in IDLE.
- key_in  in  WIDTH  key value.
- bit_valid  in  1  one-cycle strobe: bit_in is valid this cycle.
- bit_in  in  1  serial code bit, MSB first.
- unlocked  out  1  high during the OPEN window.
- alarm  out  1  high during LOCKOUT.
- busy  out  1  high in SHIFT or CHECK.
- fail_count  out  3  consecutive mismatches since last match, reset or lockout exit.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values:
  - state=IDLE.
  - key=0, shift register=0, bit counter=0, fail_count=0.
  - unlocked=0, alarm=0, busy=0.
- IDLE:
  - key_load takes priority over bit_valid in the same cycle. The bit is dropped.
  - key_load=1: key<=key_in, stay in IDLE.
  - Else bit_valid=1: shift bit_in into LSB, bit counter=1, go to SHIFT.
- SHIFT:
  - Each bit_valid shifts left and inserts bit_in at the LSB.
  - Goes to CHECK on the cycle the WIDTH-th bit is accepted.
  - key_load is ignored.
- CHECK, exactly one cycle, using a combinational equality of shift register vs key:
  - Match: fail_count<=0, OPEN timer<=OPEN_CYCLES, go to OPEN.
  - Mismatch and fail_count+1==MAX_FAIL: fail_count<=MAX_FAIL, lockout timer<=LOCKOUT_CYCLES, go to LOCKOUT.
  - Other mismatch: fail_count++, go to IDLE.
  - bit_valid during CHECK is dropped.
- OPEN:
  - unlocked=1 for exactly OPEN_CYCLES cycles, then go to IDLE.
  - bit_valid and key_load are ignored.
- LOCKOUT:
  - alarm=1 for exactly LOCKOUT_CYCLES cycles.
  - On exit: fail_count<=0, go to IDLE. All inputs ignored.
- All outputs are registered. unlocked rises the cycle after CHECK.
- Latency from the last bit_valid to unlocked high is 2 clocks.
- Bit counter is width $clog2(WIDTH+1) and is cleared on every IDLE entry.
- Reset asserted mid-operation returns every state immediately to reset values, including the key.
- Timers count down to 1 and exit on 1. No wrap-around is allowed.

Optional Feature:
- Macro: SERIAL_CODE_LOCK_TIMEOUT_EN.
- Defined:
  - In SHIFT, a gap counter clears on each bit_valid and increments otherwise.
  - On reaching TIMEOUT_CYCLES, the partial entry is discarded and the FSM returns to IDLE.
  - fail_count is not incremented.
- Undefined: SHIFT waits indefinitely and no gap counter is synthesised.

Decomposition:
- Shared package serial_code_lock_pkg holds:
  - state typedef: IDLE, SHIFT, CHECK, OPEN, LOCKOUT, 3-bit encoding;
  - default parameter constants;
  - fail_count width constant (3).
- One sub-module: eq_compare_n, parameterised WIDTH-bit equality. Per-bit XNOR AND-reduced, output 1 on equal. Instantiated once for shift register vs key.

Test Plan:
- Match:
  - Stimulus: reset; key_load key_in=8'hA5; shift bits 1,0,1,0,0,1,0,1.
  - Response: busy high during entry; unlocked high 2 cycles after the last bit, for exactly 16 cycles; fail_count=0.
- Mismatch then match:
  - Stimulus: key 8'h3C; enter 8'h3D, then 8'h3C.
  - Response: fail_count 1 after the first entry; unlocked after the second; fail_count returns to 0.
- Lockout:
  - Stimulus: key 8'hFF; enter 8'h00 three times.
  - Response: alarm high for exactly 64 cycles; bits and key_load ignored meanwhile; fail_count 0 at exit.
- Priority and ignore:
  - Stimulus: key_load and bit_valid in the same IDLE cycle; then key_load mid-SHIFT.
  - Response: new key stored and bit dropped; the mid-SHIFT key_load does not change the key.
- Reset mid-entry:
  - Stimulus: reset after 4 bits; then enter 8'h00.
  - Response: all outputs 0; key=0, so 8'h00 unlocks.
- Timeout, with SERIAL_CODE_LOCK_TIMEOUT_EN defined:
  - Stimulus: 3 bits, then a 32-cycle gap.
  - Response: return to IDLE; busy low; fail_count unchanged.
